next_pc_unit: RTL and testbench
===============================

// Module: next_pc_unit
// PURPOSE
//  - Owns the program counter. Selects the next PC from five sources: sequential, branch,
//    jump, jump-register and, optionally, exception. Holds the PC while stalled.
//  - Latches any redirect that arrives during a stall and applies it when the stall drops.
//  - Sits in the fetch stage and replaces the discrete PC-select mux and branch AND gate.
// PARAMETERS
//  - XLEN       32            address width
//  - RESET_VEC  32'h0000_0000 PC value loaded on reset
//  - EXC_VEC    32'h8000_0180 exception target (used only with NPC_EXCEPTION_EN)
//  - INC        4             sequential increment in bytes
//  - ALIGN_BITS 2             low target bits that must be zero
// PORTS
//  - clk            in   1     clock, rising-edge
//  - rst            in   1     synchronous reset, active-high
//  - stall          in   1     1 = hold PC this cycle
//  - branch         in   1     branch instruction in decode
//  - zero           in   1     ALU zero flag; branch is taken when branch & zero
//  - branch_target  in   XLEN  branch target address
//  - jump           in   1     jump request
//  - jump_target    in   XLEN  full jump address
//  - jr             in   1     jump-register request
//  - jr_target      in   XLEN  register-sourced address
//  - exc            in   1     exception request (port exists only with NPC_EXCEPTION_EN)
//  - pc             out  XLEN  current PC, registered
//  - pc_plus_inc    out  XLEN  pc + INC, combinational
//  - redirect_taken out  1     1-cycle pulse: PC loaded from a non-sequential source
//  - misalign       out  1     1-cycle pulse: applied target had nonzero low bits
// BEHAVIOUR
//  - Reset: pc=RESET_VEC, pending empty, state=RUN, redirect_taken=0, misalign=0.
//  - Source priority within a cycle: exc > jr > jump > taken branch > sequential.
//  - State RUN, stall=0:
//    - pc <= highest-priority target, else pc_plus_inc.
//    - redirect_taken=1 on the following cycle if the target was non-sequential.
//  - State RUN, stall=1: PC holds.
//    - Redirect present -> capture it into pend_tgt, go to PEND.
//    - No redirect -> go to HOLD.
//  - State HOLD, stall=1:
//    - PC holds.
//    - A redirect is captured into pend_tgt -> PEND.
//  - State HOLD, stall=0: behaves as RUN with stall=0 -> RUN.
//  - State PEND, stall=1:
//    - PC holds.
//    - A new redirect overwrites pend_tgt (most recent wins).
//  - State PEND, stall=0: pc <= pend_tgt, redirect_taken pulses, -> RUN.
//    - A same-cycle redirect input is ignored; it was already superseded.
//  - Misalignment: low ALIGN_BITS of any applied target are forced to 0.
//    - misalign pulses in the same cycle redirect_taken pulses.
//  - Wrap-around: pc_plus_inc is computed modulo 2^XLEN; 0xFFFF_FFFC + 4 -> 0x0000_0000.
//  - Reset during PEND or HOLD: the pending target is discarded, pc=RESET_VEC.
//  - Latency: redirect to new pc is 1 cycle when not stalled.
//    - When stalled: 1 cycle after stall deasserts.
// CONFIGURATION
//  - NPC_EXCEPTION_EN defined:
//    - exc port present, top priority, target EXC_VEC.
//    - exc also overrides a pending target while in PEND.
//  - NPC_EXCEPTION_EN undefined:
//    - no exc port; four sources only.
//    - EXC_VEC is unused.
// STRUCTURE
//  - Shared package npc_pkg:
//    - state enum {RUN, HOLD, PEND}.
//    - source-select enum {SRC_SEQ, SRC_BR, SRC_J, SRC_JR, SRC_EXC}.
//    - localparam defaults for RESET_VEC and EXC_VEC.
//  - Sub-module npc_priority_sel (combinational): request bits + targets -> selected target,
//    any_redirect, src code.
// TESTING
//  - Reset, then 3 idle cycles -> pc = 0x0, 0x4, 0x8, 0xC; redirect_taken stays 0.
//  - branch=1, zero=1, branch_target=0x40 at pc=0x8 -> next pc=0x40, redirect_taken pulse.
//    - With zero=0 -> next pc=0xC.
//  - jump=1 (0x100) and jr=1 (0x200) in the same cycle -> pc=0x200.
//  - stall=1 for 3 cycles, jump 0x80 in cycle 1, jr 0x90 in cycle 2 -> pc holds.
//    - On release, pc=0x90 next cycle.
//  - jr_target=0x1003 -> pc=0x1000, misalign=1 and redirect_taken=1 for one cycle.
//  - pc=0xFFFF_FFFC with no redirect -> pc=0x0.
//    - rst asserted in PEND -> pc=RESET_VEC, pending cleared, no pulse after release.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared types and defaults for the next-PC unit.
package npc_pkg;

  localparam int unsigned NPC_XLEN       = 32;
  localparam int unsigned NPC_INC        = 4;
  localparam int unsigned NPC_ALIGN_BITS = 2;
  localparam logic [31:0] NPC_RESET_VEC  = 32'h0000_0000;
  localparam logic [31:0] NPC_EXC_VEC    = 32'h8000_0180;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    PEND = 2'd2
  } npc_state_e;

  typedef enum logic [2:0] {
    SRC_SEQ = 3'd0,
    SRC_BR  = 3'd1,
    SRC_J   = 3'd2,
    SRC_JR  = 3'd3,
    SRC_EXC = 3'd4
  } npc_src_e;

endpackage

// File: rtl/npc_priority_sel.sv
// Fixed-priority next-PC source select: exc > jr > jump > taken branch > sequential.
module npc_priority_sel
  import npc_pkg::*;
#(
  parameter int unsigned XLEN = NPC_XLEN
) (
  input  logic            exc_req_i,
  input  logic [XLEN-1:0] exc_tgt_i,
  input  logic            jr_req_i,
  input  logic [XLEN-1:0] jr_tgt_i,
  input  logic            j_req_i,
  input  logic [XLEN-1:0] j_tgt_i,
  input  logic            br_req_i,
  input  logic [XLEN-1:0] br_tgt_i,
  input  logic [XLEN-1:0] seq_tgt_i,
  output logic [XLEN-1:0] sel_tgt_o,
  output logic            any_redirect_o,
  output npc_src_e        src_o
);

  // Priority encode the request bits and pick the matching target.
  always_comb begin
    sel_tgt_o      = seq_tgt_i;
    any_redirect_o = 1'b1;
    src_o          = SRC_SEQ;
    if (exc_req_i) begin
      sel_tgt_o = exc_tgt_i;
      src_o     = SRC_EXC;
    end else if (jr_req_i) begin
      sel_tgt_o = jr_tgt_i;
      src_o     = SRC_JR;
    end else if (j_req_i) begin
      sel_tgt_o = j_tgt_i;
      src_o     = SRC_J;
    end else if (br_req_i) begin
      sel_tgt_o = br_tgt_i;
      src_o     = SRC_BR;
    end else begin
      any_redirect_o = 1'b0;
    end
  end

endmodule

// File: rtl/next_pc_unit.sv
// Program counter owner for the fetch stage: source select, stall hold and
// deferred redirect. Optional exception source enabled by NPC_EXCEPTION_EN.
module next_pc_unit
  import npc_pkg::*;
#(
  parameter int unsigned     XLEN       = NPC_XLEN,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(NPC_RESET_VEC),
  parameter logic [XLEN-1:0] EXC_VEC    = XLEN'(NPC_EXC_VEC),
  parameter int unsigned     INC        = NPC_INC,
  parameter int unsigned     ALIGN_BITS = NPC_ALIGN_BITS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch,
  input  logic            zero,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            jr,
  input  logic [XLEN-1:0] jr_target,
`ifdef NPC_EXCEPTION_EN
  input  logic            exc,
`endif
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus_inc,
  output logic            redirect_taken,
  output logic            misalign
);

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

  npc_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            redir_q, redir_d;
  logic            misal_q, misal_d;

  logic            exc_req;
  logic [XLEN-1:0] sel_tgt;
  logic            any_redirect;
  npc_src_e        src;
  logic [XLEN-1:0] apply_tgt;
  logic            apply_redir;

`ifdef NPC_EXCEPTION_EN
  assign exc_req = exc;
`else
  assign exc_req = 1'b0;
`endif

  assign pc_plus_inc = pc_q + XLEN'(INC);

  npc_priority_sel #(.XLEN(XLEN)) u_sel (
    .exc_req_i      (exc_req),
    .exc_tgt_i      (EXC_VEC),
    .jr_req_i       (jr),
    .jr_tgt_i       (jr_target),
    .j_req_i        (jump),
    .j_tgt_i        (jump_target),
    .br_req_i       (branch & zero),
    .br_tgt_i       (branch_target),
    .seq_tgt_i      (pc_plus_inc),
    .sel_tgt_o      (sel_tgt),
    .any_redirect_o (any_redirect),
    .src_o          (src)
  );

  // Next-state, next-PC and pulse generation.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    redir_d     = 1'b0;
    misal_d     = 1'b0;
    apply_tgt   = sel_tgt;
    apply_redir = 1'b0;
    case (state_q)
      RUN, HOLD: begin
        if (stall) begin
          if (any_redirect) begin
            pend_d  = sel_tgt;
            state_d = PEND;
          end else begin
            state_d = HOLD;
          end
        end else begin
          apply_tgt   = sel_tgt;
          apply_redir = any_redirect;
          state_d     = RUN;
        end
      end
      PEND: begin
        if (stall) begin
          if (any_redirect) pend_d = sel_tgt;
        end else begin
          // Only an exception may supersede the deferred target on release.
          apply_tgt   = (src == SRC_EXC) ? sel_tgt : pend_q;
          apply_redir = 1'b1;
          state_d     = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (!stall && state_q != npc_state_e'(2'd3)) begin
      pc_d    = apply_tgt & ~LOW_MASK;
      redir_d = apply_redir;
      misal_d = apply_redir & (|(apply_tgt & LOW_MASK));
    end
  end

  // State and PC registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_VEC;
      pend_q  <= '0;
      redir_q <= 1'b0;
      misal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      redir_q <= redir_d;
      misal_q <= misal_d;
    end
  end

  assign pc             = pc_q;
  assign redirect_taken = redir_q;
  assign misalign       = misal_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit; define NPC_EXCEPTION_EN to cover the exception source.
module tb_next_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch;
  logic        zero;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        jr;
  logic [31:0] jr_target;
`ifdef NPC_EXCEPTION_EN
  logic        exc;
`endif
  logic [31:0] pc;
  logic [31:0] pc_plus_inc;
  logic        redirect_taken;
  logic        misalign;

  int unsigned pass_cnt = 0;
  int unsigned chk_cnt  = 0;

  always #5 clk = ~clk;

  next_pc_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .branch         (branch),
    .zero           (zero),
    .branch_target  (branch_target),
    .jump           (jump),
    .jump_target    (jump_target),
    .jr             (jr),
    .jr_target      (jr_target),
`ifdef NPC_EXCEPTION_EN
    .exc            (exc),
`endif
    .pc             (pc),
    .pc_plus_inc    (pc_plus_inc),
    .redirect_taken (redirect_taken),
    .misalign       (misalign)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic clear_in();
    stall = 1'b0; branch = 1'b0; zero = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0; jr = 1'b0; jr_target = '0;
`ifdef NPC_EXCEPTION_EN
    exc = 1'b0;
`endif
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check pc, redirect and misalign together.
  task automatic chk(input string tag, input logic [31:0] epc, input logic er, input logic em);
    check_eq({tag, ".pc"}, pc, epc);
    check_eq({tag, ".redir"}, 32'(redirect_taken), 32'(er));
    check_eq({tag, ".misal"}, 32'(misalign), 32'(em));
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    step(); step();
    chk("reset", 32'h0, 1'b0, 1'b0);
    rst = 1'b0;

    step(); chk("seq1", 32'h4, 1'b0, 1'b0);
    step(); chk("seq2", 32'h8, 1'b0, 1'b0);
    check_eq("plus_inc", pc_plus_inc, 32'hC);

    // Taken branch, then not-taken branch.
    branch = 1'b1; zero = 1'b1; branch_target = 32'h40;
    step(); chk("br_taken", 32'h40, 1'b1, 1'b0);
    zero = 1'b0; branch_target = 32'h80;
    step(); chk("br_not", 32'h44, 1'b0, 1'b0);
    clear_in();

    // jr beats jump in the same cycle.
    jump = 1'b1; jump_target = 32'h100; jr = 1'b1; jr_target = 32'h200;
    step(); chk("jr_prio", 32'h200, 1'b1, 1'b0);
    clear_in();

    // Redirects during stall: most recent wins, release-cycle input ignored.
    stall = 1'b1; jump = 1'b1; jump_target = 32'h80;
    step(); chk("stall1", 32'h200, 1'b0, 1'b0);
    jump = 1'b0; jr = 1'b1; jr_target = 32'h90;
    step(); chk("stall2", 32'h200, 1'b0, 1'b0);
    jr = 1'b0;
    step(); chk("stall3", 32'h200, 1'b0, 1'b0);
    stall = 1'b0; jump = 1'b1; jump_target = 32'h300;
    step(); chk("release", 32'h90, 1'b1, 1'b0);
    clear_in();
    step(); chk("post_rel", 32'h94, 1'b0, 1'b0);

    // Plain stall (HOLD) then release sequentially.
    stall = 1'b1;
    step(); chk("hold", 32'h94, 1'b0, 1'b0);
    stall = 1'b0;
    step(); chk("hold_rel", 32'h98, 1'b0, 1'b0);

    // HOLD then redirect while still stalled.
    stall = 1'b1;
    step(); chk("hold2", 32'h98, 1'b0, 1'b0);
    jump = 1'b1; jump_target = 32'h600;
    step(); chk("hold_pend", 32'h98, 1'b0, 1'b0);
    clear_in();
    step(); chk("hold_pend_rel", 32'h600, 1'b1, 1'b0);

    // Misaligned jr target.
    jr = 1'b1; jr_target = 32'h1003;
    step(); chk("misal", 32'h1000, 1'b1, 1'b1);
    clear_in();
    step(); chk("misal_clr", 32'h1004, 1'b0, 1'b0);

    // Misaligned deferred branch target.
    stall = 1'b1; branch = 1'b1; zero = 1'b1; branch_target = 32'h2006;
    step(); chk("misal_pend", 32'h1004, 1'b0, 1'b0);
    clear_in();
    step(); chk("misal_pend_rel", 32'h2004, 1'b1, 1'b1);

    // Wrap-around.
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    step(); chk("wrap_set", 32'hFFFF_FFFC, 1'b1, 1'b0);
    clear_in();
    check_eq("wrap_inc", pc_plus_inc, 32'h0);
    step(); chk("wrap", 32'h0, 1'b0, 1'b0);

    // Reset while a target is pending.
    step(); step();
    stall = 1'b1; jump = 1'b1; jump_target = 32'h500;
    step(); chk("pre_rst", 32'h8, 1'b0, 1'b0);
    jump = 1'b0; rst = 1'b1;
    step(); chk("rst_pend", 32'h0, 1'b0, 1'b0);
    rst = 1'b0; stall = 1'b0;
    step(); chk("rst_rel", 32'h4, 1'b0, 1'b0);

`ifdef NPC_EXCEPTION_EN
    exc = 1'b1; jr = 1'b1; jr_target = 32'h200;
    step(); chk("exc_prio", 32'h8000_0180, 1'b1, 1'b0);
    clear_in();
    stall = 1'b1; jump = 1'b1; jump_target = 32'h700;
    step();
    stall = 1'b0; jump = 1'b0; exc = 1'b1;
    step(); chk("exc_pend", 32'h8000_0180, 1'b1, 1'b0);
    clear_in();
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
